// File: rtl/oled_pkg.sv
// Shared FSM state encoding and derived-width helpers for the OLED picture streamer.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_COLS     = 128;
  localparam int unsigned DEF_PAGES    = 8;
  localparam int unsigned DEF_NUM_PICS = 4;
  localparam int unsigned DEF_ROM_LAT  = 1;

  // Index width for a power-of-two count; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned cols, input int unsigned pages,
                                         input int unsigned pics);
    return idx_w(pics) + idx_w(pages) + idx_w(cols);
  endfunction

endpackage

// File: rtl/oled_addr_gen.sv
// Column/page counters and ROM address register, updated on frame clear or byte advance.
module oled_addr_gen
  import oled_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned PAGES    = DEF_PAGES,
  parameter int unsigned NUM_PICS = DEF_NUM_PICS,
  localparam int unsigned COL_W   = idx_w(COLS),
  localparam int unsigned PAGE_W  = idx_w(PAGES),
  localparam int unsigned PIC_W   = idx_w(NUM_PICS),
  localparam int unsigned AW      = PIC_W + PAGE_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic [PIC_W-1:0]  i_pic,
  input  logic              i_mirror,
  output logic [COL_W-1:0]  o_col,
  output logic [PAGE_W-1:0] o_page,
  output logic              o_last_col,
  output logic              o_last_page,
  output logic [AW-1:0]     o_addr
);

  logic [COL_W-1:0]  r_col;
  logic [PAGE_W-1:0] r_page;
  logic [AW-1:0]     r_addr;
  logic [COL_W-1:0]  w_col_nxt;
  logic [PAGE_W-1:0] w_page_nxt;

  assign o_col       = r_col;
  assign o_page      = r_page;
  assign o_addr      = r_addr;
  assign o_last_col  = (r_col == COL_W'(COLS - 1));
  assign o_last_page = (r_page == PAGE_W'(PAGES - 1));

  always_comb begin
    w_col_nxt  = r_col;
    w_page_nxt = r_page;
    if (i_clear) begin
      w_col_nxt  = '0;
      w_page_nxt = '0;
    end else if (i_inc) begin
      w_col_nxt = r_col + COL_W'(1);
      if (o_last_col) w_page_nxt = r_page + PAGE_W'(1);
    end
  end

  // The address is loaded together with the counters so it is already on the
  // ROM bus during ISSUE; with COLS a power of two, COLS-1-col is just ~col.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col  <= '0;
      r_page <= '0;
      r_addr <= '0;
    end else if (i_clear || i_inc) begin
      r_col  <= w_col_nxt;
      r_page <= w_page_nxt;
      r_addr <= {i_pic, w_page_nxt, (i_mirror ? ~w_col_nxt : w_col_nxt)};
    end
  end

endmodule

// File: rtl/oled_pic_streamer.sv
// Streams one picture from a synchronous ROM to the pixel driver over valid/ready,
// with picture select, invert, mirror and auto-refresh. rst is asynchronous, active-low.
module oled_pic_streamer
  import oled_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned PAGES    = DEF_PAGES,
  parameter int unsigned NUM_PICS = DEF_NUM_PICS,
  parameter int unsigned ROM_LAT  = DEF_ROM_LAT,
  localparam int unsigned COL_W   = idx_w(COLS),
  localparam int unsigned PAGE_W  = idx_w(PAGES),
  localparam int unsigned PIC_W   = idx_w(NUM_PICS),
  localparam int unsigned AW      = PIC_W + PAGE_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_refresh,
  input  logic [PIC_W-1:0]  pic_sel,
  input  logic              invert,
  input  logic              mirror,
  output logic [AW-1:0]     rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              page_start,
  output logic [PAGE_W-1:0] cur_page,
  output logic              frame_done,
  output logic              busy
);

  state_t            r_state;
  logic [PIC_W-1:0]  r_pic;
  logic              r_inv;
  logic              r_mir;
  logic              r_from_done;
  logic [1:0]        r_lat;
  logic [7:0]        r_byte_data;
  logic              r_byte_valid;
  logic              r_page_start;
  logic [PAGE_W-1:0] r_cur_page;
  logic              r_frame_done;
  logic              r_busy;

  logic              w_start;
  logic              w_xfer;
  logic              w_last;
  logic [COL_W-1:0]  w_col;
  logic [PAGE_W-1:0] w_page;
  logic              w_last_col;
  logic              w_last_page;
  logic [PIC_W-1:0]  w_pic;
  logic              w_mir;

  assign w_start = (r_state == ST_IDLE) && (start || (auto_refresh && r_from_done));
  assign w_xfer  = (r_state == ST_PRESENT) && r_byte_valid && byte_ready;
  assign w_last  = w_last_col && w_last_page;
  // The first address of a frame must use the selections being latched this cycle.
  assign w_pic   = w_start ? pic_sel : r_pic;
  assign w_mir   = w_start ? mirror  : r_mir;

  oled_addr_gen #(
    .COLS     (COLS),
    .PAGES    (PAGES),
    .NUM_PICS (NUM_PICS)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start),
    .i_inc       (w_xfer && !w_last),
    .i_pic       (w_pic),
    .i_mirror    (w_mir),
    .o_col       (w_col),
    .o_page      (w_page),
    .o_last_col  (w_last_col),
    .o_last_page (w_last_page),
    .o_addr      (rom_addr)
  );

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign page_start = r_page_start;
  assign cur_page   = r_cur_page;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pic        <= '0;
      r_inv        <= 1'b0;
      r_mir        <= 1'b0;
      r_from_done  <= 1'b0;
      r_lat        <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_page_start <= 1'b0;
      r_cur_page   <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_from_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_pic   <= pic_sel;
            r_inv   <= invert;
            r_mir   <= mirror;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_lat   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat == 2'(ROM_LAT - 1)) begin
            r_byte_data  <= rom_data ^ {8{r_inv}};
            r_byte_valid <= 1'b1;
            r_page_start <= (w_col == '0);
            r_cur_page   <= w_page;
            r_state      <= ST_PRESENT;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        ST_PRESENT: begin
          if (w_xfer) begin
            r_byte_valid <= 1'b0;
            r_page_start <= 1'b0;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_from_done  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_pic_streamer.sv
// Self-checking bench: frame table plus scoreboard, backpressure, auto-refresh, reset abort, ROM_LAT=2.
module tb_oled_pic_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance: COLS=128, PAGES=8, NUM_PICS=4, ROM_LAT=1.
  logic        start, auto_refresh, invert, mirror, byte_ready;
  logic [1:0]  pic_sel;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data, byte_data;
  logic        byte_valid, page_start, frame_done, busy;
  logic [2:0]  cur_page;

  oled_pic_streamer u_dut (
    .clk(clk), .rst(rst), .start(start), .auto_refresh(auto_refresh),
    .pic_sel(pic_sel), .invert(invert), .mirror(mirror),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .page_start(page_start), .cur_page(cur_page),
    .frame_done(frame_done), .busy(busy)
  );

  logic [7:0] rom_q1;
  always @(posedge clk) rom_q1 <= rom_addr[7:0];
  assign rom_data = rom_q1;

  // Small instance: COLS=16, PAGES=4, ROM_LAT=2.
  logic        start2, ready2;
  logic [1:0]  pic_sel2;
  logic [7:0]  rom_addr2, rom_data2, byte_data2;
  logic        valid2, ps2, done2, busy2;
  logic [1:0]  cur_page2;

  oled_pic_streamer #(.COLS(16), .PAGES(4), .NUM_PICS(4), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .auto_refresh(1'b0),
    .pic_sel(pic_sel2), .invert(1'b0), .mirror(1'b0),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .byte_data(byte_data2), .byte_valid(valid2), .byte_ready(ready2),
    .page_start(ps2), .cur_page(cur_page2),
    .frame_done(done2), .busy(busy2)
  );

  logic [7:0] rom2_a, rom2_b;
  always @(posedge clk) begin
    rom2_a <= rom_addr2;
    rom2_b <= rom2_a;
  end
  assign rom_data2 = rom2_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        ps;
    logic [2:0]  page;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  pic;
    logic        inv;
    logic        mir;
    int          rmode;
    logic [11:0] first_addr;
    logic [7:0]  first_data;
    logic [11:0] b128_addr;
    logic [11:0] last_addr;
    logic [7:0]  last_data;
  } row_t;
  row_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic push_frame(input logic [1:0] pic, input logic inv, input logic mir);
    exp_t e;
    for (int pg = 0; pg < 8; pg++) begin
      for (int c = 0; c < 128; c++) begin
        e.addr = {pic, 3'(pg), 7'(mir ? 127 - c : c)};
        e.data = e.addr[7:0] ^ {8{inv}};
        e.ps   = (c == 0);
        e.page = 3'(pg);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input row_t r, input bit do_start, input bit mid_evt,
                           input bit set_auto, input int abort_at);
    int n, cyc, ps_cnt;
    bit done, held, stable;
    exp_t e;
    logic [7:0]  hd;
    logic        hps;
    logic [2:0]  hpg;
    logic [11:0] a_first, a_128, a_last;
    logic [7:0]  d_first, d_last;
    logic        ps_128;
    logic [2:0]  pg_128;
    push_frame(r.pic, r.inv, r.mir);
    if (do_start) begin
      pic_sel = r.pic; invert = r.inv; mirror = r.mir; start = 1'b1;
      @(negedge clk);
    end
    n = 0; cyc = 0; ps_cnt = 0; done = 0; held = 0;
    while (!done && cyc < 20000) begin
      cyc++;
      start = 1'b0;
      if (frame_done) done = 1;
      byte_ready = (r.rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (r.rmode == 1 && byte_valid && n == 389 && !held) begin
        byte_ready = 1'b0;
        hd = byte_data; hps = page_start; hpg = cur_page; stable = 1;
        repeat (20) begin
          @(negedge clk);
          if (!byte_valid || byte_data !== hd || page_start !== hps || cur_page !== hpg) stable = 0;
        end
        held = 1;
        chk("bp_hold_stable", 32'(stable), 32'd1);
        chk("bp_hold_page", 32'(hpg), 32'd3);
        byte_ready = 1'b1;
      end
      if (!done && byte_valid && byte_ready) begin
        if (abort_at == n) begin
          rst = 1'b0;
          #1;
          chk("abort_outputs_zero",
              32'({rom_addr, byte_data, byte_valid, page_start, cur_page, frame_done, busy}), 32'd0);
          stable = 1;
          repeat (3) begin
            @(negedge clk);
            if (frame_done) stable = 0;
          end
          rst = 1'b1;
          repeat (10) begin
            @(negedge clk);
            if (frame_done || busy || byte_valid) stable = 0;
          end
          chk("abort_stays_idle", 32'(stable), 32'd1);
          sb.delete();
          return;
        end
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty at xfer %0d", n);
        end else begin
          e = sb.pop_front();
          checks++;
          if (rom_addr !== e.addr || byte_data !== e.data || page_start !== e.ps || cur_page !== e.page) begin
            errors++;
            $display("FAIL xfer%0d got a=%h d=%h ps=%b pg=%0d want a=%h d=%h ps=%b pg=%0d",
                     n, rom_addr, byte_data, page_start, cur_page, e.addr, e.data, e.ps, e.page);
          end
        end
        if (n == 0) begin a_first = rom_addr; d_first = byte_data; end
        if (n == 128) begin a_128 = rom_addr; ps_128 = page_start; pg_128 = cur_page; end
        a_last = rom_addr; d_last = byte_data;
        if (page_start) ps_cnt++;
        n++;
        if (mid_evt && n == 500) begin start = 1'b1; pic_sel = 2'd3; end
        if (set_auto && n == 1000) auto_refresh = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL frame_timeout xfers %0d", n);
    end
    chk("xfer_count", 32'(n), 32'd1024);
    chk("page_start_count", 32'(ps_cnt), 32'd8);
    chk("first_addr", 32'(a_first), 32'(r.first_addr));
    chk("first_data", 32'(d_first), 32'(r.first_data));
    chk("b128", 32'({a_128, ps_128, pg_128}), 32'({r.b128_addr, 1'b1, 3'd1}));
    chk("last_addr", 32'(a_last), 32'(r.last_addr));
    chk("last_data", 32'(d_last), 32'(r.last_data));
    chk("done_busy", 32'({byte_valid, busy}), 32'b01);
    if (set_auto) begin
      @(negedge clk);
      chk("auto_idle_gap", 32'({busy, frame_done}), 32'b00);
      @(negedge clk);
      chk("auto_restart", 32'({busy, rom_addr}), 32'({1'b1, 12'hC00}));
    end else begin
      @(negedge clk);
      chk("busy_drop1", 32'({busy, frame_done}), 32'b00);
      @(negedge clk);
      chk("busy_drop2", 32'({busy, frame_done, byte_valid}), 32'b000);
    end
  endtask

  initial begin
    int n2, cyc2, last_x, min_sp;
    bit done_f;
    logic [7:0] ea;
    tbl[0] = '{2'd2, 1'b0, 1'b0, 0, 12'h800, 8'h00, 12'h880, 12'hBFF, 8'hFF};
    tbl[1] = '{2'd0, 1'b1, 1'b1, 0, 12'h07F, 8'h80, 12'h0FF, 12'h380, 8'h7F};
    tbl[2] = '{2'd2, 1'b0, 1'b0, 1, 12'h800, 8'h00, 12'h880, 12'hBFF, 8'hFF};
    tbl[3] = '{2'd1, 1'b1, 1'b0, 0, 12'h400, 8'hFF, 12'h480, 12'h7FF, 8'h00};
    tbl[4] = '{2'd3, 1'b0, 1'b0, 0, 12'hC00, 8'h00, 12'hC80, 12'hFFF, 8'hFF};

    start = 0; auto_refresh = 0; invert = 0; mirror = 0; byte_ready = 0; pic_sel = 0;
    start2 = 0; ready2 = 0; pic_sel2 = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dut1", 32'({rom_addr, byte_data, byte_valid, page_start, cur_page, frame_done, busy}), 32'd0);
    chk("reset_dut2", 32'({rom_addr2, byte_data2, valid2, ps2, cur_page2, done2, busy2}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame(tbl[i], 1'b1, 1'b0, 1'b0, -1);

    // Mid-frame start/pic change is ignored; auto-refresh then restarts on pic 3.
    run_frame(tbl[0], 1'b1, 1'b1, 1'b1, -1);
    auto_refresh = 1'b0;
    run_frame(tbl[4], 1'b0, 1'b0, 1'b0, -1);

    run_frame(tbl[3], 1'b1, 1'b0, 1'b0, 300);
    run_frame(tbl[1], 1'b1, 1'b0, 1'b0, -1);

    // Small instance with two-cycle ROM latency.
    pic_sel2 = 2'd1; ready2 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n2 = 0; cyc2 = 0; last_x = 0; min_sp = 1000; done_f = 0;
    while (!done_f && cyc2 < 2000) begin
      cyc2++;
      if (done2) done_f = 1;
      if (valid2 && ready2) begin
        ea = 8'h40 + 8'(n2);
        checks++;
        if (rom_addr2 !== ea || byte_data2 !== ea || ps2 !== (n2 % 16 == 0) || cur_page2 !== 2'(n2 / 16)) begin
          errors++;
          $display("FAIL lat2_xfer%0d got a=%h d=%h ps=%b pg=%0d want a=%h", n2, rom_addr2, byte_data2,
                   ps2, cur_page2, ea);
        end
        if (n2 > 0 && cyc2 - last_x < min_sp) min_sp = cyc2 - last_x;
        last_x = cyc2;
        n2++;
      end
      if (!done_f) @(negedge clk);
    end
    chk("lat2_done", 32'(done_f), 32'd1);
    chk("lat2_count", 32'(n2), 32'd64);
    chk("lat2_spacing", 32'(min_sp), 32'd4);
    @(negedge clk);
    chk("lat2_busy_drop", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_pic_streamer.md
Name: oled_pic_streamer

Overview:
- Parametrised successor to the single-picture OLED display top.
- Fetches one full picture from a synchronous picture ROM that holds NUM_PICS pictures, page by page and column by column.
- Presents each byte to the pixel/I2C driver over a valid/ready stream, with page-start and frame-done markers.
- Adds run-time picture select, invert and horizontal-mirror modes, and a continuous auto-refresh mode.

Parameters:
- COLS, 128: columns per page; power of two.
- PAGES, 8: 8-pixel pages per picture; power of two.
- NUM_PICS, 4: pictures in ROM; power of two, at least 2.
- ROM_LAT, 1: ROM read latency in clocks; legal values 1 or 2.
- Derived constants: COL_W = clog2(COLS), PAGE_W = clog2(PAGES), PIC_W = clog2(NUM_PICS), AW = PIC_W + PAGE_W + COL_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- auto_refresh  in  1  when 1, a new frame starts automatically after frame_done.
- pic_sel  in  PIC_W  picture index; latched at frame start.
- invert  in  1  XOR every byte with 8'hFF; latched at frame start.
- mirror  in  1  output columns in order COLS-1..0; latched at frame start.
- rom_addr  out  AW  {pic, page, col}; registered.
- rom_data  in  8  ROM byte, valid ROM_LAT clocks after rom_addr.
- byte_data  out  8  pixel byte to the driver.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  driver accepts; a transfer occurs when byte_valid && byte_ready.
- page_start  out  1  qualifies byte_valid; high on col index 0 of each page, which lets the driver emit a page/column address command first.
- cur_page  out  PAGE_W  page of the current byte.
- frame_done  out  1  one-clock pulse after the last byte transfers.
- busy  out  1  high from frame start through the frame_done cycle.

Behaviour:
- Reset: asynchronous, active-low, held while rst=0. On reset, all outputs are 0, the FSM returns to IDLE and the counters clear.
- Reset mid-frame aborts the frame. No frame_done is produced. After release, the block waits for a new start.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - A frame start occurs when start=1, or when auto_refresh=1 and the previous state was DONE.
  - On frame start: latch pic_sel, invert and mirror; clear page and col indices; set busy=1; go to ISSUE.
  - Start while busy is ignored and not queued.
- ISSUE: drive rom_addr = {pic_q, page, mirror_q ? COLS-1-col : col}. Go to WAIT.
- WAIT: count ROM_LAT clocks, then capture rom_data XOR {8{invert_q}} into byte_data. Set byte_valid=1, and page_start=(col==0). Go to PRESENT.
- PRESENT:
  - byte_data, page_start and cur_page are held stable while byte_valid && !byte_ready.
  - On a transfer, byte_valid drops in the next cycle.
  - If col < COLS-1: col+1, go to ISSUE.
  - Else if page < PAGES-1: col=0, page+1, go to ISSUE.
  - Else: go to DONE.
- DONE: frame_done=1 for one clock. busy drops in the following cycle. Go to IDLE; with auto_refresh=1, IDLE immediately restarts and re-samples pic_sel, invert and mirror.
- Throughput: at most one byte per (ROM_LAT+2) clocks. byte_ready may be held high permanently.
- byte_valid never depends combinationally on byte_ready.
- Counter wrap: col and page never exceed COLS-1 and PAGES-1. Exactly COLS*PAGES transfers occur per frame.
- Changes to pic_sel, invert or mirror mid-frame have no effect until the next frame start.
- ROM_LAT=1 with COLS=128, PAGES=8, NUM_PICS=4 yields an address layout of {pic[1:0], page[2:0], col[6:0]} (12 bits).

Decomposition:
- Shared package oled_pkg holds the derived-width functions/constants (COL_W, PAGE_W, PIC_W, AW) and the FSM state encoding, shared with pixel_ctrl.
- One natural sub-module: oled_addr_gen, holding the col/page counters, the mirror mapping and the address concatenation, with inc/clear/last_col/last_page outputs.
- The FSM and output register stay in the top.

Test Plan:
1. Reset behaviour: start=1, pic_sel=2, invert=0, mirror=0, byte_ready=1, ROM model returns data=addr[7:0].
   - Required: 1024 transfers in order; first rom_addr=12'h800, last =12'hBFF.
   - page_start is seen exactly 8 times, at col 0.
   - frame_done pulses once; busy=0 two cycles later.
2. invert=1, mirror=1, pic_sel=0.
   - Required: first byte address 12'h07F, with byte_data = ~8'h7F = 8'h80.
   - Byte 128 is address 12'h0FF with page_start=1 and cur_page=1.
3. Backpressure: byte_ready toggled randomly, held low 20 cycles at page 3 col 5.
   - Required: byte_data, page_start and cur_page stable, byte_valid held high.
   - No byte is lost or duplicated; the scoreboard matches case 1.
4. Mid-frame events: start pulsed and pic_sel changed to 3 mid-frame, then auto_refresh=1.
   - Required: mid-frame start is ignored and the current frame stays on pic 2.
   - The next frame begins one cycle after DONE using pic 3, with no idle gap beyond IDLE.
5. Reset abort: rst asserted low at byte 300 for 3 cycles.
   - Required: outputs go to 0 asynchronously, no frame_done, and the block stays IDLE until start.
6. ROM_LAT=2, COLS=16, PAGES=4: full frame.
   - Required: 64 transfers, each byte matching the ROM 2 cycles after its address.
   - Minimum 4-cycle byte spacing with byte_ready=1.
